// File: rtl/button_pkg.sv
// Shared types and 12 MHz timing defaults for the push-button reader.
package button_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE        = 2'd0,
        BTN_ARM_PRESS   = 2'd1,
        BTN_HELD        = 2'd2,
        BTN_ARM_RELEASE = 2'd3
    } btn_state_t;

    // 10 ms debounce and 1 s long press at a 12 MHz system clock.
    localparam int BTN_DEBOUNCE_CYCLES_12MHZ = 120000;
    localparam int BTN_LONG_CYCLES_12MHZ     = 12000000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; both stages reset to RESET_VAL.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/button_reader.sv
// Debounced push-button reader: level, press/release strobes and a wrapping press counter.
// Long-press strobe is built only when BUTTON_READER_LONG_PRESS_EN is defined.
module button_reader
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_12MHZ,
    parameter int LONG_CYCLES     = BTN_LONG_CYCLES_12MHZ,
    parameter int ACTIVE_LOW      = 1,
    parameter int CNT_W           = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pin_btn,
    output logic             btn_level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic [CNT_W-1:0] press_count
);

    localparam int               DCW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCW-1:0]   DB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic             IDLE_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic             pin_sync;
    logic             s_pressed;

    btn_state_t       state_reg, state_next;
    logic [DCW-1:0]   cnt_reg, cnt_next;
    logic             level_reg, level_next;
    logic             press_reg, press_next;
    logic             release_reg, release_next;
    logic [CNT_W-1:0] count_reg, count_next;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (IDLE_PIN)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pin_btn),
        .q     (pin_sync)
    );

    assign s_pressed = (ACTIVE_LOW != 0) ? ~pin_sync : pin_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= BTN_IDLE;
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            level_reg   <= level_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            count_reg   <= count_next;
        end
    end

    // The debounce counter restarts from zero on every state change.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        level_next   = level_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        count_next   = count_reg;
        case (state_reg)
            BTN_IDLE: begin
                if (s_pressed) begin
                    state_next = BTN_ARM_PRESS;
                    cnt_next   = '0;
                end
            end
            BTN_ARM_PRESS: begin
                if (!s_pressed) begin
                    state_next = BTN_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == DB_LAST) begin
                    state_next = BTN_HELD;
                    cnt_next   = '0;
                    press_next = 1'b1;
                    level_next = 1'b1;
                    count_next = count_reg + CNT_W'(1);
                end else begin
                    cnt_next = cnt_reg + DCW'(1);
                end
            end
            BTN_HELD: begin
                if (!s_pressed) begin
                    state_next = BTN_ARM_RELEASE;
                    cnt_next   = '0;
                end
            end
            BTN_ARM_RELEASE: begin
                if (s_pressed) begin
                    state_next = BTN_HELD;
                    cnt_next   = '0;
                end else if (cnt_reg == DB_LAST) begin
                    state_next   = BTN_IDLE;
                    cnt_next     = '0;
                    release_next = 1'b1;
                    level_next   = 1'b0;
                end else begin
                    cnt_next = cnt_reg + DCW'(1);
                end
            end
            default: begin
                state_next = BTN_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef BUTTON_READER_LONG_PRESS_EN
    localparam int             LCW       = $clog2(LONG_CYCLES + 1);
    localparam logic [LCW-1:0] LONG_LAST = LCW'(LONG_CYCLES - 1);
    localparam logic [LCW-1:0] LONG_FULL = LCW'(LONG_CYCLES);

    logic [LCW-1:0] long_cnt_reg, long_cnt_next;
    logic           long_reg, long_next;
    logic           enter_held;

    assign enter_held = (state_reg == BTN_ARM_PRESS) && (state_next == BTN_HELD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_cnt_reg <= '0;
            long_reg     <= 1'b0;
        end else begin
            long_cnt_reg <= long_cnt_next;
            long_reg     <= long_next;
        end
    end

    // Saturating at LONG_CYCLES guarantees one strobe per press; a strobe that would
    // coincide with the release strobe is dropped to keep strobes mutually exclusive.
    always_comb begin
        long_cnt_next = long_cnt_reg;
        long_next     = 1'b0;
        if (enter_held) begin
            long_cnt_next = '0;
        end else if (state_reg == BTN_HELD || state_reg == BTN_ARM_RELEASE) begin
            if (long_cnt_reg == LONG_LAST && !release_next)
                long_next = 1'b1;
            if (long_cnt_reg != LONG_FULL)
                long_cnt_next = long_cnt_reg + LCW'(1);
        end
    end

    assign long_pulse = long_reg;
`else
    assign long_pulse = 1'b0;
`endif

    assign btn_level     = level_reg;
    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;
    assign press_count   = count_reg;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader (DEBOUNCE_CYCLES=8, LONG_CYCLES=32, ACTIVE_LOW=1).
module tb_button_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pin_btn = 1'b1;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [1:0] press_count;

    int n_cmp = 0;
    int n_bad = 0;

    int edge_no = 0;
    int n_press = 0;
    int n_rel = 0;
    int n_long = 0;
    int n_long_total = 0;
    int n_overlap = 0;
    int press_edge = -1;
    int long_edge = -1;

    typedef struct {
        logic       pin;
        int         cycles;
        int         exp_press;
        int         exp_rel;
        logic       exp_level;
        logic [1:0] exp_count;
    } vec_t;

    vec_t vecs[12];

    button_reader #(
        .DEBOUNCE_CYCLES (8),
        .LONG_CYCLES     (32),
        .ACTIVE_LOW      (1),
        .CNT_W           (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pin_btn       (pin_btn),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic clear_counts();
        edge_no    = 0;
        n_press    = 0;
        n_rel      = 0;
        n_long     = 0;
        press_edge = -1;
        long_edge  = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_no++;
        if (press_pulse) begin
            n_press++;
            press_edge = edge_no;
        end
        if (release_pulse) n_rel++;
        if (long_pulse) begin
            n_long++;
            n_long_total++;
            long_edge = edge_no;
        end
        if (int'(press_pulse) + int'(release_pulse) + int'(long_pulse) > 1) n_overlap++;
    endtask

    task automatic run(input logic pin, input int cycles);
        pin_btn = pin;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".btn_level"},     int'(btn_level),     0);
        check({tag, ".press_pulse"},   int'(press_pulse),   0);
        check({tag, ".release_pulse"}, int'(release_pulse), 0);
        check({tag, ".long_pulse"},    int'(long_pulse),    0);
        check({tag, ".press_count"},   int'(press_count),   0);
    endtask

    initial begin
        // Starts with one press already accepted (count 1, level 1).
        vecs[0]  = '{1'b1,  3, 0, 0, 1'b1, 2'd1};  // release bounce of 3 cycles
        vecs[1]  = '{1'b0,  5, 0, 0, 1'b1, 2'd1};
        vecs[2]  = '{1'b1, 14, 0, 1, 1'b0, 2'd1};  // clean release
        vecs[3]  = '{1'b0,  5, 0, 0, 1'b0, 2'd1};  // press bounce of 5 cycles
        vecs[4]  = '{1'b1,  6, 0, 0, 1'b0, 2'd1};
        vecs[5]  = '{1'b0, 14, 1, 0, 1'b1, 2'd2};
        vecs[6]  = '{1'b1, 14, 0, 1, 1'b0, 2'd2};
        vecs[7]  = '{1'b0, 14, 1, 0, 1'b1, 2'd3};
        vecs[8]  = '{1'b1, 14, 0, 1, 1'b0, 2'd3};
        vecs[9]  = '{1'b0, 14, 1, 0, 1'b1, 2'd0};  // counter wraps
        vecs[10] = '{1'b1, 14, 0, 1, 1'b0, 2'd0};
        vecs[11] = '{1'b0, 14, 1, 0, 1'b1, 2'd1};

        // Reset state with the pin idle.
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b1, 3);

        // First press: strobe on edge 11 after the pin goes low.
        clear_counts();
        run(1'b0, 14);
        check("first.press_edge", press_edge, 11);
        check("first.press_cnt", n_press, 1);
        check("first.level", int'(btn_level), 1);
        check("first.count", int'(press_count), 1);

        for (int v = 0; v < 12; v++) begin
            clear_counts();
            run(vecs[v].pin, vecs[v].cycles);
            check($sformatf("vec%0d.press", v), n_press, vecs[v].exp_press);
            check($sformatf("vec%0d.release", v), n_rel, vecs[v].exp_rel);
            check($sformatf("vec%0d.level", v), int'(btn_level), int'(vecs[v].exp_level));
            check($sformatf("vec%0d.count", v), int'(press_count), int'(vecs[v].exp_count));
        end
        run(1'b1, 14);

        // Long hold of 60 cycles.
        clear_counts();
        run(1'b0, 60);
        check("long.press_edge", press_edge, 11);
`ifdef BUTTON_READER_LONG_PRESS_EN
        check("long.count", n_long, 1);
        check("long.delay", long_edge - press_edge, 32);
`else
        check("long.count", n_long, 0);
`endif
        clear_counts();
        run(1'b1, 14);
        check("long.release", n_rel, 1);
        check("long.level", int'(btn_level), 0);

        // Reset during ARM_PRESS, pin stays pressed through and after reset.
        run(1'b0, 5);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        run(1'b0, 14);
        check("midreset.press_edge", press_edge, 11);
        check("midreset.press_cnt", n_press, 1);
        check("midreset.count", int'(press_count), 1);
        check("midreset.level", int'(btn_level), 1);

        check("strobe_overlap", n_overlap, 0);
`ifndef BUTTON_READER_LONG_PRESS_EN
        check("long_never", n_long_total, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_reader.md
# button_reader

Debounced push-button input block: the input-side counterpart of the LED/pin drivers. It synchronises a raw, bouncing button pin into the `clk` domain and filters it with a debounce state machine. It emits a clean pressed level, single-cycle press/release strobes, an optional long-press strobe, and a wrapping press counter. The press counter is sized so it can directly select one of the board LEDs.

## Interface
- `DEBOUNCE_CYCLES`, default 120000: cycles the synchronised level must stay stable before it is accepted (10 ms at 12 MHz); must be ≥ 1.
- `LONG_CYCLES`, default 12000000: cycles held before a long press is reported (1 s at 12 MHz); must be > `DEBOUNCE_CYCLES`.
- `ACTIVE_LOW`, default 1: 1 means the pin reads 0 when pressed (pull-up button).
- `CNT_W`, default 2: width of `press_count`.
- `clk` in 1: 12 MHz system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pin_btn` in 1: raw asynchronous button pin.
- `btn_level` out 1: debounced pressed state (1 = pressed).
- `press_pulse` out 1: one-cycle strobe on an accepted press.
- `release_pulse` out 1: one-cycle strobe on an accepted release.
- `long_pulse` out 1: one-cycle strobe when a press reaches `LONG_CYCLES`.
- `press_count` out `CNT_W`: number of accepted presses, modulo 2^`CNT_W`.

## Operation
- **Synchroniser:** two flops; both reset to the unpressed pin level (`ACTIVE_LOW` ? 1 : 0). The output is normalised to `s_pressed` (1 = pressed).
- **Debounce counter:** width `$clog2(DEBOUNCE_CYCLES+1)`. It clears on every state transition.
- **FSM states:** IDLE, ARM_PRESS, HELD, ARM_RELEASE.
  - IDLE: if `s_pressed`, go to ARM_PRESS.
  - ARM_PRESS: if `!s_pressed`, return to IDLE (bounce rejected, no strobes). Otherwise increment the counter. When the counter reaches `DEBOUNCE_CYCLES-1` with `s_pressed` still high, go to HELD, assert `press_pulse` and `btn_level`, and increment `press_count`.
  - HELD: if `!s_pressed`, go to ARM_RELEASE.
  - ARM_RELEASE: if `s_pressed`, return to HELD (release rejected, `btn_level` stays 1). Otherwise increment the counter. At `DEBOUNCE_CYCLES-1`, go to IDLE, assert `release_pulse`, and clear `btn_level`.
- **Strobes:** all strobes are registered, high for exactly one cycle, and never asserted together.
- **Press counter:** `press_count` wraps from 2^`CNT_W`-1 to 0 without any flag.
- **Reset:** asserting `rst_n` low, including mid-debounce, forces IDLE, clears all counters, and drives every output to 0 asynchronously.

## Timing
- **Reset values:** `btn_level` = 0, `press_pulse` = 0, `release_pulse` = 0, `long_pulse` = 0, `press_count` = 0.
- **Press latency:** `press_pulse` rises on the (`DEBOUNCE_CYCLES`+3)th rising edge after the first edge that samples a stably pressed pin. That count is 2 synchroniser edges, 1 edge into ARM_PRESS, and `DEBOUNCE_CYCLES` count edges. `btn_level` rises on the same edge.
- **Release latency:** identical to press latency, for `release_pulse` and the falling edge of `btn_level`.
- **Bounce rejection:** a bounce shorter than `DEBOUNCE_CYCLES` cycles, as seen at the synchroniser output, produces no strobe and no level change.
- **Inputs:** there is no handshake; strobes are fire-and-forget, and consumers must sample every cycle.

## Configuration
- **`BUTTON_READER_LONG_PRESS_EN` defined:**
  - A long counter of width `$clog2(LONG_CYCLES+1)` clears on entry to HELD from ARM_PRESS.
  - It counts every cycle in HELD and ARM_RELEASE, including through rejected releases.
  - It asserts `long_pulse` once when it reaches `LONG_CYCLES-1`, then saturates.
  - It emits at most one `long_pulse` per accepted press.
- **Macro undefined:** `long_pulse` is tied to 0 and no long counter is instantiated.

## Structure
- **Package `button_pkg`:** holds the FSM state enum (`BTN_IDLE`, `BTN_ARM_PRESS`, `BTN_HELD`, `BTN_ARM_RELEASE`) and the default cycle constants for 12 MHz.
- **Sub-module `sync_2ff`:** a generic two-flop synchroniser with a reset-value parameter. It is the only sub-module; the FSM, the counters, and the long-press logic live in `button_reader`.

## Test plan
Unless stated otherwise, benches use `DEBOUNCE_CYCLES`=8, `LONG_CYCLES`=32, `ACTIVE_LOW`=1.
- Reset with the pin held at 1 -> all outputs 0. Drive the pin to 0 and hold it -> `press_pulse` high for 1 cycle on edge 11, `btn_level`=1, `press_count`=1.
- Pin pulses to 0 for 5 cycles, then back to 1 -> no strobes, `btn_level` stays 0, `press_count` stays 0.
- While held, the pin bounces high for 3 cycles -> no `release_pulse`. A clean release held for ≥ 11 cycles -> exactly one `release_pulse`, `btn_level`=0.
- Five clean presses -> `press_count` sequence 1, 2, 3, 0, 1.
- With the macro defined, hold for 60 cycles -> exactly one `long_pulse`, 32 cycles after `press_pulse`. With the macro undefined -> `long_pulse` is never asserted.
- Assert `rst_n`=0 mid-ARM_PRESS (pin 0 for 5 cycles), then release reset with the pin still 0 -> `press_pulse` fires 11 edges after reset release, `press_count`=1.
